// File: rtl/mem_port_arbiter_if.sv
// Memory-side req/gnt/rvalid bus of the unified instruction/data memory port.
// master: arbiter side; slave: memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and data (MEM) stages onto one single-port memory, data first.
// Optional MEM_ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IF_req_i,
    input  logic [ADDR_WIDTH-1:0] IF_addr_i,
    input  logic                  IF_flush_i,
    output logic [DATA_WIDTH-1:0] IF_rdata_o,
    output logic                  IF_rvalid_o,
    output logic                  IF_stall_o,
    input  logic                  MEM_req_i,
    input  logic                  MEM_we_i,
    input  logic [3:0]            MEM_be_i,
    input  logic [ADDR_WIDTH-1:0] MEM_addr_i,
    input  logic [DATA_WIDTH-1:0] MEM_wdata_i,
    output logic [DATA_WIDTH-1:0] MEM_rdata_o,
    output logic                  MEM_rvalid_o,
    output logic                  MEM_stall_o,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]           perf_if_stall_o,
    output logic [31:0]           perf_mem_stall_o,
`endif
    mem_port_arbiter_if.master    mem
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t                r_state;
    owner_t                r_owner;
    logic                  r_drop;
    logic [3:0]            r_starve_cnt;
    logic                  r_req;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_idle;
    logic w_mem_win;
    logic w_if_win;
    logic w_resp;
    logic w_if_flush_hit;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_mem_win = w_idle & MEM_req_i & (~IF_req_i | (r_starve_cnt < BURST_MAX));
    assign w_if_win  = w_idle & ~w_mem_win & IF_req_i;
    assign w_resp    = (r_state == ST_RESP) & mem.mem_rvalid_i;
    assign w_if_flush_hit = (r_owner == OWN_IF) & IF_flush_i;

    // A flush landing in the response cycle itself still kills the delivery.
    assign IF_rvalid_o  = w_resp & (r_owner == OWN_IF) & ~r_drop & ~IF_flush_i;
    assign MEM_rvalid_o = w_resp & (r_owner == OWN_MEM);
    assign IF_rdata_o   = mem.mem_rdata_i;
    assign MEM_rdata_o  = mem.mem_rdata_i;
    assign IF_stall_o   = IF_req_i & ~IF_rvalid_o;
    assign MEM_stall_o  = MEM_req_i & ~MEM_rvalid_o;

    assign mem.mem_req_o   = r_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_be_o    = r_be;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_win) begin
                        r_owner <= OWN_MEM;
                        r_req   <= 1'b1;
                        r_we    <= MEM_we_i;
                        r_be    <= MEM_be_i;
                        r_addr  <= MEM_addr_i;
                        r_wdata <= MEM_wdata_i;
                        r_state <= ST_REQ;
                    end else if (w_if_win) begin
                        r_owner <= OWN_IF;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_be    <= 4'hF;
                        r_addr  <= IF_addr_i;
                        r_wdata <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= ST_RESP;
                    end
                    if (w_if_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (mem.mem_rvalid_i) begin
                        r_drop  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_if_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (!IF_req_i || w_if_win) begin
                r_starve_cnt <= '0;
            end else if (w_mem_win && (r_starve_cnt < BURST_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_if  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (IF_stall_o && (r_perf_if != '1)) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (MEM_stall_o && (r_perf_mem != '1)) begin
                r_perf_mem <= r_perf_mem + 32'd1;
            end
        end
    end

    assign perf_if_stall_o  = r_perf_if;
    assign perf_mem_stall_o = r_perf_mem;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small gnt/rvalid memory responder.
// Define MEM_ARB_PERF_CNT_EN to also cover the stall counters.
module tb_mem_port_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BURST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          IF_req_i = 1'b0;
    logic [AW-1:0] IF_addr_i = '0;
    logic          IF_flush_i = 1'b0;
    logic [DW-1:0] IF_rdata_o;
    logic          IF_rvalid_o;
    logic          IF_stall_o;
    logic          MEM_req_i = 1'b0;
    logic          MEM_we_i = 1'b0;
    logic [3:0]    MEM_be_i = '0;
    logic [AW-1:0] MEM_addr_i = '0;
    logic [DW-1:0] MEM_wdata_i = '0;
    logic [DW-1:0] MEM_rdata_o;
    logic          MEM_rvalid_o;
    logic          MEM_stall_o;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   perf_if_stall_o;
    logic [31:0]   perf_mem_stall_o;
`endif

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DATA_BURST(BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .IF_req_i(IF_req_i),
        .IF_addr_i(IF_addr_i),
        .IF_flush_i(IF_flush_i),
        .IF_rdata_o(IF_rdata_o),
        .IF_rvalid_o(IF_rvalid_o),
        .IF_stall_o(IF_stall_o),
        .MEM_req_i(MEM_req_i),
        .MEM_we_i(MEM_we_i),
        .MEM_be_i(MEM_be_i),
        .MEM_addr_i(MEM_addr_i),
        .MEM_wdata_i(MEM_wdata_i),
        .MEM_rdata_o(MEM_rdata_o),
        .MEM_rvalid_o(MEM_rvalid_o),
        .MEM_stall_o(MEM_stall_o),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_if_stall_o(perf_if_stall_o),
        .perf_mem_stall_o(perf_mem_stall_o),
`endif
        .mem(mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory responder: gnt after hold_left refused cycles, rvalid 1+rv_extra cycles after gnt.
    logic model_en  = 1'b1;
    int   hold_left = 0;
    int   rv_extra  = 0;
    int   rv_cnt    = 0;
    logic [31:0] rv_data = '0;

    initial begin
        mif.mem_gnt_i    = 1'b0;
        mif.mem_rvalid_i = 1'b0;
        mif.mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (model_en) begin
                mif.mem_gnt_i    = 1'b0;
                mif.mem_rvalid_i = 1'b0;
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mif.mem_rvalid_i = 1'b1;
                        mif.mem_rdata_i  = rv_data;
                    end
                end
                if (mif.mem_req_o) begin
                    if (hold_left > 0) begin
                        hold_left--;
                    end else begin
                        mif.mem_gnt_i = 1'b1;
                        rv_cnt  = 1 + rv_extra;
                        rv_data = mem_data(mif.mem_addr_o);
                    end
                end
            end
        end
    end

    logic [31:0] glog[$];
    int n_if_rv  = 0;
    int n_mem_rv = 0;

    always @(posedge clk) begin
        if (!rst && mif.mem_req_o && mif.mem_gnt_i) glog.push_back(mif.mem_addr_o);
        if (IF_rvalid_o)  n_if_rv++;
        if (MEM_rvalid_o) n_mem_rv++;
    end

    initial begin
        int base;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_req",    32'(mif.mem_req_o), 32'd0);
        check_eq("rst_we",     32'(mif.mem_we_o), 32'd0);
        check_eq("rst_be",     32'(mif.mem_be_o), 32'd0);
        check_eq("rst_addr",   mif.mem_addr_o, 32'd0);
        check_eq("rst_wdata",  mif.mem_wdata_o, 32'd0);
        check_eq("rst_ifrv",   32'(IF_rvalid_o), 32'd0);
        check_eq("rst_memrv",  32'(MEM_rvalid_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single fetch, response in the third cycle counting the request cycle
        IF_req_i  = 1'b1;
        IF_addr_i = 32'h100;
        @(negedge clk);
        check_eq("f1_stall_c0", 32'(IF_stall_o), 32'd1);
        check_eq("f1_req_c0",   32'(mif.mem_req_o), 32'd0);
        tick();
        @(negedge clk);
        check_eq("f1_req_c1",   32'(mif.mem_req_o), 32'd1);
        check_eq("f1_addr_c1",  mif.mem_addr_o, 32'h100);
        check_eq("f1_we_c1",    32'(mif.mem_we_o), 32'd0);
        check_eq("f1_be_c1",    32'(mif.mem_be_o), 32'hF);
        check_eq("f1_stall_c1", 32'(IF_stall_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("f1_rvalid",   32'(IF_rvalid_o), 32'd1);
        check_eq("f1_rdata",    IF_rdata_o, 32'h0050_0093);
        check_eq("f1_stall_c2", 32'(IF_stall_o), 32'd0);
        check_eq("f1_memrv",    32'(MEM_rvalid_o), 32'd0);
        tick();
        IF_req_i = 1'b0;
        tick();

        // Contention: store wins, fetch follows
        IF_req_i    = 1'b1;
        IF_addr_i   = 32'h200;
        MEM_req_i   = 1'b1;
        MEM_we_i    = 1'b1;
        MEM_be_i    = 4'hF;
        MEM_addr_i  = 32'h2000;
        MEM_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("c_ifstall_c0",  32'(IF_stall_o), 32'd1);
        check_eq("c_memstall_c0", 32'(MEM_stall_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("c_addr_c1",  mif.mem_addr_o, 32'h2000);
        check_eq("c_we_c1",    32'(mif.mem_we_o), 32'd1);
        check_eq("c_wdata_c1", mif.mem_wdata_o, 32'hDEAD_BEEF);
        check_eq("c_ifstall_c1", 32'(IF_stall_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("c_memrv_c2",    32'(MEM_rvalid_o), 32'd1);
        check_eq("c_memstall_c2", 32'(MEM_stall_o), 32'd0);
        check_eq("c_ifrv_c2",     32'(IF_rvalid_o), 32'd0);
        check_eq("c_ifstall_c2",  32'(IF_stall_o), 32'd1);
        tick();
        MEM_req_i = 1'b0;
        MEM_we_i  = 1'b0;
        @(negedge clk);
        check_eq("c_ifstall_c3", 32'(IF_stall_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("c_addr_c4",    mif.mem_addr_o, 32'h200);
        check_eq("c_we_c4",      32'(mif.mem_we_o), 32'd0);
        check_eq("c_ifstall_c4", 32'(IF_stall_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("c_ifrv_c5",   32'(IF_rvalid_o), 32'd1);
        check_eq("c_rdata_c5",  IF_rdata_o, 32'h0200_C0DE);
        tick();
        IF_req_i = 1'b0;
        tick();

        // Starvation: 4 data grants then one fetch grant, repeating
        glog.delete();
        IF_req_i   = 1'b1;
        IF_addr_i  = 32'h300;
        MEM_req_i  = 1'b1;
        MEM_we_i   = 1'b0;
        MEM_addr_i = 32'h3000;
        repeat (30) tick();
        IF_req_i  = 1'b0;
        MEM_req_i = 1'b0;
        check_eq("sv_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("sv_grant%0d", i),
                     (i < glog.size()) ? glog[i] : 32'hFFFF_FFFF,
                     ((i % 5) == 4) ? 32'h300 : 32'h3000);
        end
        tick();
        tick();

        // Flush during RESP: 0x40 discarded, 0x80 delivered
        base      = n_if_rv;
        rv_extra  = 2;
        IF_req_i  = 1'b1;
        IF_addr_i = 32'h40;
        tick();
        @(negedge clk);
        check_eq("fl_addr_c1", mif.mem_addr_o, 32'h40);
        tick();
        IF_flush_i = 1'b1;
        IF_addr_i  = 32'h80;
        @(negedge clk);
        check_eq("fl_ifrv_c2", 32'(IF_rvalid_o), 32'd0);
        tick();
        IF_flush_i = 1'b0;
        @(negedge clk);
        check_eq("fl_ifrv_c3", 32'(IF_rvalid_o), 32'd0);
        tick();
        @(negedge clk);
        check_eq("fl_mrv_c4",   32'(mif.mem_rvalid_i), 32'd1);
        check_eq("fl_ifrv_c4",  32'(IF_rvalid_o), 32'd0);
        check_eq("fl_stall_c4", 32'(IF_stall_o), 32'd1);
        tick();
        rv_extra = 0;
        tick();
        @(negedge clk);
        check_eq("fl_addr_c6", mif.mem_addr_o, 32'h80);
        check_eq("fl_req_c6",  32'(mif.mem_req_o), 32'd1);
        tick();
        @(negedge clk);
        check_eq("fl_ifrv_c7",  32'(IF_rvalid_o), 32'd1);
        check_eq("fl_rdata_c7", IF_rdata_o, 32'h0080_C0DE);
        tick();
        IF_req_i = 1'b0;
        check_eq("fl_rv_count", 32'(n_if_rv - base), 32'd1);
        tick();

        // Flush coinciding with the response drops it
        IF_req_i  = 1'b1;
        IF_addr_i = 32'hC0;
        tick();
        tick();
        IF_flush_i = 1'b1;
        @(negedge clk);
        check_eq("fs_mrv",  32'(mif.mem_rvalid_i), 32'd1);
        check_eq("fs_ifrv", 32'(IF_rvalid_o), 32'd0);
        tick();
        IF_flush_i = 1'b0;
        IF_req_i   = 1'b0;
        tick();

        // Flush during a data access has no effect
        MEM_req_i  = 1'b1;
        MEM_we_i   = 1'b0;
        MEM_addr_i = 32'h500;
        tick();
        IF_flush_i = 1'b1;
        tick();
        IF_flush_i = 1'b0;
        @(negedge clk);
        check_eq("fm_memrv",  32'(MEM_rvalid_o), 32'd1);
        check_eq("fm_rdata",  MEM_rdata_o, 32'h0500_C0DE);
        tick();
        MEM_req_i = 1'b0;
        tick();

        // Gnt backpressure: 5 refused cycles, request held 6 cycles
        base        = n_mem_rv;
        hold_left   = 5;
        MEM_req_i   = 1'b1;
        MEM_we_i    = 1'b1;
        MEM_be_i    = 4'h3;
        MEM_addr_i  = 32'h600;
        MEM_wdata_i = 32'h1234_5678;
        for (int c = 1; c <= 6; c++) begin
            tick();
            @(negedge clk);
            check_eq($sformatf("bp_req_c%0d", c),   32'(mif.mem_req_o), 32'd1);
            check_eq($sformatf("bp_addr_c%0d", c),  mif.mem_addr_o, 32'h600);
            check_eq($sformatf("bp_wdata_c%0d", c), mif.mem_wdata_o, 32'h1234_5678);
            check_eq($sformatf("bp_be_c%0d", c),    32'(mif.mem_be_o), 32'h3);
            check_eq($sformatf("bp_stall_c%0d", c), 32'(MEM_stall_o), 32'd1);
        end
        tick();
        @(negedge clk);
        check_eq("bp_req_c7",   32'(mif.mem_req_o), 32'd0);
        check_eq("bp_memrv_c7", 32'(MEM_rvalid_o), 32'd1);
        tick();
        MEM_req_i = 1'b0;
        MEM_we_i  = 1'b0;
        tick();
        tick();
        check_eq("bp_rv_count", 32'(n_mem_rv - base), 32'd1);

        // Reset in RESP, then stray rvalid/gnt
        rv_extra  = 3;
        IF_req_i  = 1'b1;
        IF_addr_i = 32'h700;
        tick();
        tick();
        @(negedge clk);
        model_en = 1'b0;
        rv_cnt   = 0;
        check_eq("rr_inresp_req", 32'(mif.mem_req_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        IF_req_i         = 1'b0;
        mif.mem_rvalid_i = 1'b1;
        mif.mem_gnt_i    = 1'b1;
        mif.mem_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk);
        check_eq("rr_req",   32'(mif.mem_req_o), 32'd0);
        check_eq("rr_we",    32'(mif.mem_we_o), 32'd0);
        check_eq("rr_be",    32'(mif.mem_be_o), 32'd0);
        check_eq("rr_addr",  mif.mem_addr_o, 32'd0);
        check_eq("rr_wdata", mif.mem_wdata_o, 32'd0);
        check_eq("rr_ifrv",  32'(IF_rvalid_o), 32'd0);
        check_eq("rr_memrv", 32'(MEM_rvalid_o), 32'd0);
`ifdef MEM_ARB_PERF_CNT_EN
        check_eq("rr_perf_if",  perf_if_stall_o, 32'd0);
        check_eq("rr_perf_mem", perf_mem_stall_o, 32'd0);
`endif
        tick();
        mif.mem_rvalid_i = 1'b0;
        mif.mem_gnt_i    = 1'b0;
        @(negedge clk);
        check_eq("rr_req_after", 32'(mif.mem_req_o), 32'd0);
        check_eq("rr_ifrv_after", 32'(IF_rvalid_o), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
